second_largest: RTL and testbench
=================================

SECOND_LARGEST -- requirements
Module: second_largest

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, bit width of din and dout (unsigned).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port: din  input  DATA_WIDTH  unsigned sample, accepted on every rising edge while resetn=1.
REQ-005 Port: dout  output  DATA_WIDTH  registered second-largest value among all samples accepted since the last reset.
REQ-006 Port (only with SECOND_LARGEST_VALID_EN): dout_valid  output  1  high once at least two samples have been accepted since reset.

Function
REQ-007 The block SHALL hold two registers: max_q (largest accepted sample) and sec_q (second largest); dout SHALL equal sec_q.
REQ-008 On each rising edge with resetn=1, if din >= max_q, the block SHALL load sec_q<=max_q and max_q<=din.
REQ-009 Else if din > sec_q, the block SHALL load sec_q<=din and leave max_q unchanged.
REQ-010 Otherwise both registers SHALL hold.
REQ-011 Duplicates count as distinct samples: a repeat of the current maximum SHALL make dout equal to that maximum (e.g. 5,5 -> dout=5).
REQ-012 Latency: a sample presented before edge N SHALL be reflected on dout immediately after edge N (one-cycle registered latency); dout SHALL never depend combinationally on din.
REQ-013 Comparisons SHALL be unsigned and full DATA_WIDTH; no saturation or wrap is possible because only stored input values are moved.
REQ-014 Before two samples arrive, dout SHALL read 0 (reset value); a single sample x SHALL give dout=0 and max_q=x.
REQ-015 Input value 0 SHALL be accepted like any other value; all-ones input SHALL be handled as the maximum representable value.

Reset
REQ-016 While resetn=0 at a rising edge, max_q, sec_q and dout SHALL become 0 and din SHALL be ignored for that edge.
REQ-017 Reset asserted mid-stream SHALL discard all history; the first edge with resetn=1 afterwards SHALL be treated as the first sample.
REQ-018 With SECOND_LARGEST_VALID_EN, the sample counter and dout_valid SHALL reset to 0.

Configuration
REQ-019 Macro SECOND_LARGEST_VALID_EN: when defined, the block SHALL include a 2-bit saturating accepted-sample counter and the dout_valid port, with dout_valid=1 from the edge accepting the second sample until the next reset.
REQ-020 When SECOND_LARGEST_VALID_EN is undefined, the counter and the dout_valid port SHALL be absent, and dout behaviour SHALL be identical in both builds.

Structure
REQ-021 Package second_largest_pkg SHALL hold the DATA_WIDTH default constant and a packed typedef of the {max, sec} rank pair.
REQ-022 One sub-module, second_largest_rank_update, SHALL implement the purely combinational next-state logic (inputs din, max, sec; outputs next max, next sec); the top SHALL contain only registers, reset and the optional counter.

Verification
REQ-023 Reset, then din 0x02,0x06,0x00,0x0E,0x0C,0x01 on consecutive edges -> dout after each edge: 0x00,0x02,0x02,0x06,0x0C,0x0C.
REQ-024 Duplicate maximum: after reset, din 0x05,0x05 -> dout 0x00 then 0x05; a third 0x03 keeps dout 0x05.
REQ-025 Descending stream: din 0x09,0x08,0x07 -> dout 0x00,0x08,0x08.
REQ-026 Reset mid-stream: after 0x0E,0x0C (dout 0x0C), a resetn=0 edge -> dout 0; then din 0x01,0x03 -> dout 0x00,0x01.
REQ-027 Extremes at DATA_WIDTH=32: din 0xFFFFFFFF,0x00000000,0xFFFFFFFF -> dout 0,0,0xFFFFFFFF.
REQ-028 With SECOND_LARGEST_VALID_EN: dout_valid is 0 after reset and after the first sample, 1 after the second sample, and stays 1 until the next reset.

Source files
------------

// File: rtl/second_largest_pkg.sv
// -----------------------------------------------------------------------------
// second_largest_pkg
// Shared constants and types for the second_largest block.
//   DATA_WIDTH_DEFAULT : default sample width (unsigned)
//   rank_pair_t        : packed {max, sec} rank pair at the default width
// -----------------------------------------------------------------------------
package second_largest_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  // Running ranking of the stream: largest sample and runner-up.
  typedef struct packed {
    logic [DATA_WIDTH_DEFAULT-1:0] max;
    logic [DATA_WIDTH_DEFAULT-1:0] sec;
  } rank_pair_t;

endpackage : second_largest_pkg

// File: rtl/second_largest_rank_update.sv
// -----------------------------------------------------------------------------
// second_largest_rank_update
// Purely combinational next-state logic for the {max, sec} ranking.
// Ports:
//   din      in  DATA_WIDTH  incoming unsigned sample
//   max_i    in  DATA_WIDTH  current largest sample
//   sec_i    in  DATA_WIDTH  current second-largest sample
//   max_o    out DATA_WIDTH  next largest sample
//   sec_o    out DATA_WIDTH  next second-largest sample
// -----------------------------------------------------------------------------
module second_largest_rank_update
  import second_largest_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] max_i,
  input  logic [DATA_WIDTH-1:0] sec_i,
  output logic [DATA_WIDTH-1:0] max_o,
  output logic [DATA_WIDTH-1:0] sec_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latches.
    max_o = max_i;
    sec_o = sec_i;
    // ">=" (not ">") so a repeat of the maximum is ranked as a distinct
    // sample and pushes the old maximum down into the runner-up slot.
    if (din >= max_i) begin
      sec_o = max_i;
      max_o = din;
    end else if (din > sec_i) begin
      sec_o = din;
    end
  end

endmodule : second_largest_rank_update

// File: rtl/second_largest.sv
// -----------------------------------------------------------------------------
// second_largest
// Tracks the second-largest unsigned sample seen since the last reset.
// One sample is accepted on every rising clk edge while resetn is high;
// dout is registered (one-cycle latency, no combinational path from din).
// Ports:
//   clk        in   1           clock, rising edge
//   resetn     in   1           synchronous active-low reset
//   din        in   DATA_WIDTH  unsigned sample
//   dout       out  DATA_WIDTH  second-largest accepted sample (0 until two)
//   dout_valid out  1           only with SECOND_LARGEST_VALID_EN: high once
//                               at least two samples have been accepted
// Configuration macro: SECOND_LARGEST_VALID_EN (adds sample counter and
// dout_valid; dout behaviour is identical in both builds).
// -----------------------------------------------------------------------------
module second_largest
  import second_largest_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
`ifdef SECOND_LARGEST_VALID_EN
  ,
  output logic                  dout_valid
`endif
);

  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [DATA_WIDTH-1:0] sec_q, sec_d;

  second_largest_rank_update #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rank_update (
    .din   (din),
    .max_i (max_q),
    .sec_i (sec_q),
    .max_o (max_d),
    .sec_o (sec_d)
  );

  // NOTE: reset is synchronous here: it is only seen at a rising clk edge,
  // and din is ignored on that edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // the pre-edge values regardless of statement order.
      max_q <= '0;
      sec_q <= '0;
    end else begin
      max_q <= max_d;
      sec_q <= sec_d;
    end
  end

  assign dout = sec_q;

`ifdef SECOND_LARGEST_VALID_EN
  // Saturating count of accepted samples; only "at least two" matters.
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != 2'd3) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q >= 2 exactly when bit 1 is set.
  assign dout_valid = cnt_q[1];
`endif

endmodule : second_largest

// File: tb/tb_second_largest.sv
// -----------------------------------------------------------------------------
// tb_second_largest
// Directed vectors for second_largest at DATA_WIDTH=32. Each vector gives the
// resetn/din applied before an edge and the hand-computed dout (and
// dout_valid, when SECOND_LARGEST_VALID_EN is defined) expected right after
// that edge. A scoreboard queue decouples stimulus from the monitor.
// -----------------------------------------------------------------------------
module tb_second_largest;

  localparam int DW = 32;

  logic          clk;
  logic          resetn;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
`ifdef SECOND_LARGEST_VALID_EN
  logic          dout_valid;
`endif

  second_largest #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .dout       (dout)
`ifdef SECOND_LARGEST_VALID_EN
    ,
    .dout_valid (dout_valid)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          rst_n;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
    logic          exp_valid;
  } vec_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] exp_dout;
    logic          exp_valid;
  } exp_t;

  localparam int NVEC = 33;

  vec_t vecs [NVEC] = '{
    // reset edge with non-zero din: din must be ignored
    '{1'b0, 32'h0000_00AA, 32'h0000_0000, 1'b0},
    // mixed stream
    '{1'b1, 32'h0000_0002, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_0006, 32'h0000_0002, 1'b1},
    '{1'b1, 32'h0000_0000, 32'h0000_0002, 1'b1},
    '{1'b1, 32'h0000_000E, 32'h0000_0006, 1'b1},
    '{1'b1, 32'h0000_000C, 32'h0000_000C, 1'b1},
    '{1'b1, 32'h0000_0001, 32'h0000_000C, 1'b1},
    // duplicate maximum
    '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_0005, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_0005, 32'h0000_0005, 1'b1},
    '{1'b1, 32'h0000_0003, 32'h0000_0005, 1'b1},
    // descending stream
    '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_0009, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_0008, 32'h0000_0008, 1'b1},
    '{1'b1, 32'h0000_0007, 32'h0000_0008, 1'b1},
    // reset mid-stream
    '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_000E, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_000C, 32'h0000_000C, 1'b1},
    '{1'b0, 32'h0000_0007, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_0003, 32'h0000_0001, 1'b1},
    // extremes
    '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0},
    '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1},
    '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1},
    // all-ones din during reset is ignored; single sample then gives 0
    '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_0003, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_0002, 32'h0000_0002, 1'b1},
    '{1'b1, 32'h0000_0002, 32'h0000_0002, 1'b1},
    // zero samples accepted like any other value
    '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1},
    '{1'b1, 32'h0000_0004, 32'h0000_0000, 1'b1}
  };

  exp_t sb_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int idx,
                       input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[vec %0d]: got 0x%08h, expected 0x%08h", name, idx, got, want);
    end
  endtask

  // Monitor: every edge has a registered result; compare it 1 time unit
  // after the edge against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("dout", e.idx, dout, e.exp_dout);
`ifdef SECOND_LARGEST_VALID_EN
        check("dout_valid", e.idx, {{(DW-1){1'b0}}, dout_valid},
              {{(DW-1){1'b0}}, e.exp_valid});
`endif
      end
    end
  end

  // Stimulus: drive on the falling edge, push the expectation for the
  // following rising edge.
  initial begin
    exp_t e;
    resetn = 1'b0;
    din    = '0;
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      resetn      = vecs[i].rst_n;
      din         = vecs[i].din;
      e.idx       = i;
      e.exp_dout  = vecs[i].exp_dout;
      e.exp_valid = vecs[i].exp_valid;
      sb_q.push_back(e);
    end
    for (int c = 0; c < 20 && sb_q.size() != 0; c++) begin
      @(posedge clk);
      #2;
    end
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_second_largest
